// File: rtl/ahb_reg_bridge.sv
// AHB5-Lite slave that turns each accepted transfer into one req/ack access on a
// simple register bus, with wait states until ack and a two-cycle ERROR response.
module ahb_reg_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [31:0]           haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [31:0]           hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [31:0]           hrdata,
  output logic                  reg_req,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr,
  output logic [31:0]           reg_wdata,
  output logic [3:0]            reg_wstrb,
  input  logic                  reg_ack,
  input  logic [31:0]           reg_rdata,
  input  logic                  reg_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [3:0]            r_wstrb;
  logic [CNT_W-1:0]      r_cnt;
  logic [31:0]           r_rdata;

  logic                  w_addr_phase;
  logic                  w_accept;
  logic                  w_illegal;
  logic [3:0]            w_strb;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_timeout;
  logic                  w_rd_done;
  logic                  w_unused_ok;

  // Only states that drive hreadyout=1 can own a new address phase.
  assign w_addr_phase = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
  assign w_accept     = w_addr_phase && hsel && htrans[1] && hready;

  assign w_illegal = (hsize > 3'd2)
                  || ((hsize == 3'd1) && haddr[0])
                  || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  always_comb begin
    w_strb = 4'b0000;
    case (hsize)
      3'd0:    w_strb = 4'b0001 << haddr[1:0];
      3'd1:    w_strb = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_strb = 4'b1111;
      default: w_strb = 4'b0000;
    endcase
  end

  // The counter sits at zero outside ACCESS, so entering ACCESS starts from zero.
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_LIMIT);
  assign w_rd_done = (r_state == S_ACCESS) && reg_ack && !reg_err && !r_wr;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    reg_req     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR2: begin
        hresp = (r_state == S_ERR2);
        if (w_accept) begin
          w_state_nxt = w_illegal ? S_ERR1 : S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        reg_req   = 1'b1;
        hreadyout = 1'b0;
        // An ack in the expiry cycle takes priority over the timeout.
        if (reg_ack) begin
          w_state_nxt = reg_err ? S_ERR1 : S_DONE;
        end else if (w_timeout) begin
          w_state_nxt = S_ERR1;
        end
      end
      S_ERR1: begin
        hresp       = 1'b1;
        hreadyout   = 1'b0;
        w_state_nxt = S_ERR2;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wstrb <= 4'b0000;
      r_cnt   <= '0;
      r_rdata <= 32'h0;
    end else begin
      if (w_accept && !w_illegal) begin
        r_addr  <= haddr[ADDR_WIDTH-1:0];
        r_wr    <= hwrite;
        r_wstrb <= w_strb;
      end
      if (r_state == S_ACCESS) begin
        r_cnt <= w_cnt_inc;
      end else begin
        r_cnt <= '0;
      end
      if (w_rd_done) begin
        r_rdata <= reg_rdata;
      end
    end
  end

  // Write data is passed straight through; AHB holds hwdata during wait states.
  assign reg_wdata = hwdata;
  assign reg_addr  = r_addr;
  assign reg_wr    = r_wr;
  assign reg_wstrb = r_wstrb;
  assign hrdata    = r_rdata;

  assign w_unused_ok = ^{hburst, hprot, haddr};

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Bench for ahb_reg_bridge: directed table, multi-cycle corner sequences and
// randomized transfers checked against a transaction-level reference model.
module tb_ahb_reg_bridge;

  localparam int TO = 4;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [3:0]  hprot = 4'h0;
  logic [31:0] hwdata = 32'h0;
  wire         hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        reg_req;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_hrdata;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_reg_bridge #(
    .ADDR_WIDTH    (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hprot    (hprot),
    .hwdata   (hwdata),
    .hready   (hready),
    .hreadyout(hreadyout),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .reg_req  (reg_req),
    .reg_addr (reg_addr),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .reg_wstrb(reg_wstrb),
    .reg_ack  (reg_ack),
    .reg_rdata(reg_rdata),
    .reg_err  (reg_err)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        exp_resp;
    logic [3:0]  exp_strb;
    int          exp_cycles;
    int          exp_reqs;
    logic [31:0] exp_hrdata;
  } vec_t;

  typedef struct {
    int          cycles;
    int          reqs;
    int          err_cycles;
    logic        saw_err1;
    logic        done;
    logic        resp;
    logic [31:0] rdata;
    logic [15:0] addr;
    logic [3:0]  strb;
    logic        wr;
    logic [31:0] wdata;
  } res_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after a falling edge at which hreadyout was 1: drives the address
  // phase, then plays the register side and observes the data phase to completion.
  task automatic xfer(input vec_t v, input logic [1:0] trans, output res_t r);
    r = '{default: 0};
    hsel   = 1'b1;
    htrans = trans;
    haddr  = v.addr;
    hwrite = v.wr;
    hsize  = v.size;
    hwdata = v.wdata;
    for (int c = 0; c < 64 && !r.done; c++) begin
      @(negedge hclk);
      r.cycles = r.cycles + 1;
      if (reg_req) begin
        r.reqs  = r.reqs + 1;
        r.addr  = reg_addr;
        r.strb  = reg_wstrb;
        r.wr    = reg_wr;
        r.wdata = reg_wdata;
      end
      if (hresp) begin
        r.err_cycles = r.err_cycles + 1;
        if (!hreadyout) r.saw_err1 = 1'b1;
      end
      if (hreadyout) begin
        r.done  = 1'b1;
        r.resp  = hresp;
        r.rdata = hrdata;
      end
      if (c == 0) begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      reg_ack   = reg_req && ((r.reqs - 1) == v.lat);
      reg_err   = v.err;
      reg_rdata = v.rdata;
    end
  endtask

  task automatic check_xfer(input string tag, input vec_t v, input res_t r);
    check({tag, "_done"}, 32'(r.done), 32'd1);
    check({tag, "_resp"}, 32'(r.resp), 32'(v.exp_resp));
    check({tag, "_cycles"}, 32'(r.cycles), 32'(v.exp_cycles));
    check({tag, "_reqs"}, 32'(r.reqs), 32'(v.exp_reqs));
    check({tag, "_hrdata"}, r.rdata, v.exp_hrdata);
    if (v.exp_resp) begin
      check({tag, "_errlen"}, 32'(r.err_cycles), 32'd2);
      check({tag, "_err1"}, 32'(r.saw_err1), 32'd1);
    end else begin
      check({tag, "_errlen"}, 32'(r.err_cycles), 32'd0);
    end
    if (v.exp_reqs > 0) begin
      check({tag, "_addr"}, 32'(r.addr), 32'(v.addr[15:0]));
      check({tag, "_strb"}, 32'(r.strb), 32'(v.exp_strb));
      check({tag, "_wr"}, 32'(r.wr), 32'(v.wr));
      if (v.wr) check({tag, "_wdata"}, r.wdata, v.wdata);
    end
  endtask

  // Transaction-level reference: legality by size/alignment, strobes from the
  // byte count, outcome and data-phase length from ack latency vs timeout.
  task automatic predict(inout vec_t v);
    int   nbytes;
    logic legal;
    nbytes = 1 << v.size;
    legal  = (v.size <= 3'd2) && ((v.addr % nbytes) == 0);
    v.exp_strb = legal ? 4'(((1 << nbytes) - 1) << (v.addr % 4)) : 4'h0;
    if (!legal) begin
      v.exp_resp = 1'b1; v.exp_cycles = 2; v.exp_reqs = 0;
    end else if (v.lat < TO) begin
      v.exp_reqs = v.lat + 1;
      if (v.err) begin
        v.exp_resp = 1'b1; v.exp_cycles = v.lat + 3;
      end else begin
        v.exp_resp = 1'b0; v.exp_cycles = v.lat + 2;
        if (!v.wr) model_hrdata = v.rdata;
      end
    end else begin
      v.exp_resp = 1'b1; v.exp_cycles = TO + 2; v.exp_reqs = TO;
    end
    v.exp_hrdata = model_hrdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    res_t r;
    int   burst_cycles;

    //                wr  addr          sz  wdata          lat err rdata          resp strb  cyc reqs hrdata
    tbl[0]  = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 0,  1'b0, 32'h0,         1'b0, 4'hF, 2, 1, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         0,  1'b0, 32'hDEAD_BEEF, 1'b0, 4'hF, 2, 1, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 32'h0000_0013, 3'd0, 32'hAA00_0000, 0,  1'b0, 32'h0,         1'b0, 4'h8, 2, 1, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 32'h0000_0012, 3'd1, 32'h5566_0000, 0,  1'b0, 32'h0,         1'b0, 4'hC, 2, 1, 32'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 32'h0000_0002, 3'd2, 32'h0,         0,  1'b0, 32'h1111_1111, 1'b1, 4'h0, 2, 0, 32'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 32'h0000_0020, 3'd2, 32'hCAFE_F00D, 1,  1'b1, 32'h0,         1'b1, 4'hF, 4, 2, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b0, 32'h0000_0024, 3'd2, 32'h0,         99, 1'b0, 32'h2222_2222, 1'b1, 4'hF, 6, 4, 32'hDEAD_BEEF};
    tbl[7]  = '{1'b0, 32'h0000_0028, 3'd2, 32'h0,         3,  1'b0, 32'h1234_5678, 1'b0, 4'hF, 5, 4, 32'h1234_5678};
    tbl[8]  = '{1'b1, 32'h0000_0000, 3'd3, 32'h0,         0,  1'b0, 32'h0,         1'b1, 4'h0, 2, 0, 32'h1234_5678};
    tbl[9]  = '{1'b0, 32'h0000_0001, 3'd1, 32'h0,         0,  1'b0, 32'h3333_3333, 1'b1, 4'h0, 2, 0, 32'h1234_5678};
    tbl[10] = '{1'b0, 32'h0000_002C, 3'd2, 32'h0,         0,  1'b1, 32'hFFFF_0000, 1'b1, 4'hF, 3, 1, 32'h1234_5678};
    tbl[11] = '{1'b0, 32'h0001_0031, 3'd0, 32'h0,         2,  1'b0, 32'hA5A5_A5A5, 1'b0, 4'h2, 4, 3, 32'hA5A5_A5A5};

    // Reset values.
    repeat (3) @(negedge hclk);
    check("rst_hreadyout", 32'(hreadyout), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'h0);
    check("rst_reg_req", 32'(reg_req), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wstrb", 32'(reg_wstrb), 32'd0);
    hresetn = 1'b1;

    // Reset asserted in the middle of an access; a stale ack afterwards is ignored.
    @(negedge hclk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'h0BAD_F00D;
    @(negedge hclk);
    check("midrst_req_before", 32'(reg_req), 32'd1);
    hsel = 1'b0; htrans = 2'b00;
    #2 hresetn = 1'b0;
    reg_ack = 1'b1; reg_err = 1'b0; reg_rdata = 32'h5A5A_5A5A;
    #1;
    check("midrst_req_async", 32'(reg_req), 32'd0);
    check("midrst_hreadyout", 32'(hreadyout), 32'd1);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    check("postrst_req", 32'(reg_req), 32'd0);
    check("postrst_hreadyout", 32'(hreadyout), 32'd1);
    check("postrst_hresp", 32'(hresp), 32'd0);
    check("postrst_hrdata", hrdata, 32'h0);
    reg_ack = 1'b0;

    // Directed table, issued back to back.
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i], 2'b10, r);
      check_xfer($sformatf("tbl%0d", i), tbl[i], r);
    end
    model_hrdata = tbl[11].exp_hrdata;

    // 4-beat INCR write burst with immediate acks: no gaps between beats.
    burst_cycles = 0;
    hburst = 3'b001;
    for (int b = 0; b < 4; b++) begin
      v = '{default: 0};
      v.wr = 1'b1; v.addr = 32'h100 + 32'(4 * b); v.size = 3'd2;
      v.wdata = $urandom; v.lat = 0;
      predict(v);
      xfer(v, (b == 0) ? 2'b10 : 2'b11, r);
      check_xfer($sformatf("burst%0d", b), v, r);
      burst_cycles += r.cycles;
    end
    hburst = 3'b000;
    check("burst_total_cycles", 32'(burst_cycles), 32'd8);

    // IDLE with hsel=1: zero-wait OKAY, no register access.
    hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = 32'h50;
    for (int k = 0; k < 2; k++) begin
      @(negedge hclk);
      check($sformatf("idle%0d_hreadyout", k), 32'(hreadyout), 32'd1);
      check($sformatf("idle%0d_hresp", k), 32'(hresp), 32'd0);
      check($sformatf("idle%0d_req", k), 32'(reg_req), 32'd0);
    end
    hsel = 1'b0;

    // Randomized transfers against the reference model.
    for (int n = 0; n < 40; n++) begin
      v = '{default: 0};
      v.wr    = 1'($urandom_range(1, 0));
      v.size  = ($urandom_range(7, 0) == 0) ? 3'd3 : 3'($urandom_range(2, 0));
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.lat   = $urandom_range(6, 0);
      v.err   = ($urandom_range(3, 0) == 0);
      v.rdata = $urandom;
      predict(v);
      xfer(v, ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b10, r);
      check_xfer($sformatf("rnd%0d", n), v, r);
      if ($urandom_range(3, 0) == 0) @(negedge hclk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_reg_bridge.md
# ahb_reg_bridge

AHB5-Lite slave that terminates one slot of the AHB-Lite fabric and converts each accepted transfer into a single request/acknowledge access on a simple register bus. Each peripheral's register file uses it to sit behind the AHB interconnect. The bridge:

- inserts wait states until the register side acknowledges;
- returns the two-cycle AHB ERROR response for register-side errors, timeouts and illegal transfers.

## Interface

Parameters:

- ADDR_WIDTH, 16: width of reg_addr; taken from haddr[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 256: maximum ACCESS cycles without reg_ack before ERROR. 0 disables the timeout.

Ports:

- hclk  in  1  bus clock.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select.
- haddr  in  32  address.
- htrans  in  2  transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type; not decoded.
- hprot  in  4  protection; not decoded.
- hwdata  in  32  write data, valid in data phase.
- hready  in  1  fabric HREADY, the muxed ready.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- reg_req  out  1  register access request, level.
- reg_addr  out  ADDR_WIDTH  byte address.
- reg_wr  out  1  1 = write.
- reg_wdata  out  32  write data.
- reg_wstrb  out  4  byte strobes.
- reg_ack  in  1  access complete, single-cycle pulse.
- reg_rdata  in  32  read data, valid with reg_ack.
- reg_err  in  1  access error, valid with reg_ack.

## Operation

- **Transfer accepted:** on a rising hclk edge with hsel=1, htrans[1]=1 and hready=1. The bridge registers haddr, hwrite and hsize.
- **IDLE or BUSY with hsel=1:** zero-wait OKAY; no register access.
- **Illegal transfer:** hsize>2, or misalignment (hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]≠0). The bridge goes straight to ERR1 and issues no reg_req.
- **reg_wstrb:**
  - hsize=0: one-hot at haddr[1:0].
  - hsize=1: 4'b0011 or 4'b1100 by haddr[1].
  - hsize=2: 4'b1111.
  - Reads drive the same strobes.
- **reg_wdata:** combinationally equals hwdata. This is valid because AHB holds hwdata stable during data-phase wait states.
- **States:**
  - IDLE: hreadyout=1, hresp=0. A legal accepted transfer goes to ACCESS; an illegal one goes to ERR1.
  - ACCESS: reg_req=1, hreadyout=0, timeout counter increments.
    - reg_ack with reg_err=0 → DONE. On reads, hrdata captures reg_rdata.
    - reg_ack with reg_err=1 → ERR1.
    - Counter reaches TIMEOUT_CYCLES without reg_ack → ERR1, reg_req drops.
  - DONE: hreadyout=1, hresp=0. Samples the next address phase like IDLE; with no new transfer → IDLE.
  - ERR1: hresp=1, hreadyout=0. Always → ERR2.
  - ERR2: hresp=1, hreadyout=1. Samples the next address phase like IDLE, else → IDLE.
- **Timeout counter:** width $clog2(TIMEOUT_CYCLES+1). Cleared on entering ACCESS.
- **hrdata:** holds its last value outside read completion. It is not zeroed on writes or errors.
- **hburst and hprot:** ignored. Each beat of a burst is an independent access.

## Timing

- **Reset values:** hreadyout=1, hresp=0, hrdata=0, reg_req=0, reg_wr=0, reg_addr=0, reg_wstrb=0, state IDLE.
- **Reset mid-operation:** reg_req deasserts asynchronously; a pending reg_ack after reset is ignored.
- **Sequence from address-phase edge E0:**
  - Cycle after E0: ACCESS, reg_req=1.
  - reg_ack seen at edge E1 → DONE after E1; the master completes at E2.
  - Minimum data phase is 2 cycles, i.e. 1 wait state.
- **reg_req:** stays high while in ACCESS and drops the cycle after reg_ack is sampled. reg_addr, reg_wr and reg_wstrb are stable throughout.
- **ERROR response:** ERR1 then ERR2, exactly two cycles, matching the AHB two-cycle ERROR rule. A master that cancels during ERR1 by driving htrans=IDLE has that IDLE treated as no transfer.
- **Pipelining:** a new address phase is accepted in DONE or ERR2. There are no idle gaps between back-to-back transfers.
- **Timeout:** TIMEOUT_CYCLES=N with no reg_ack gives N ACCESS cycles, then ERR1. A reg_ack arriving in the same cycle as expiry wins; no error is raised.

## Test plan

- **Reset:** assert hresetn=0 mid-ACCESS → reg_req=0 immediately; hreadyout=1, hresp=0 after release.
- **Write then read:**
  - NONSEQ write, haddr=0x0000_0010, hsize=2, hwdata=0xDEAD_BEEF, reg_ack one cycle after reg_req → reg_addr=0x0010, reg_wstrb=4'hF, reg_wdata=0xDEAD_BEEF, one wait state, OKAY.
  - Read from the same address returning 0xDEAD_BEEF → hrdata=0xDEAD_BEEF at completion.
- **Byte and halfword strobes:**
  - Byte write to 0x13 → reg_wstrb=4'b1000.
  - Halfword write to 0x12 → reg_wstrb=4'b1100.
- **Illegal transfer:** word access to 0x02 → no reg_req; hresp=1 for 2 cycles, hreadyout 0 then 1.
- **Register error and timeout:**
  - reg_ack with reg_err=1 → two-cycle ERROR.
  - TIMEOUT_CYCLES=4 with no ack → 4 ACCESS cycles, then ERROR.
  - Ack coincident with the 4th cycle → OKAY.
- **Back-to-back:** 4-beat INCR write burst with immediate acks → 4 reg_req pulses and 4 OKAY completions, no idle cycles; IDLE transfer with hsel=1 → zero-wait OKAY.
